// File: rtl/hpdcache_pkg.sv
// Shared cache constants and the LFSR feedback table used by victim selection.
package hpdcache_pkg;

  localparam int unsigned HPDCACHE_MAX_WAYS = 32;

  // Right-shifting Galois feedback masks for 8..16 bit random sources.
  function automatic logic [15:0] hpdcache_lfsr_taps(input int unsigned width);
    logic [15:0] taps;
    case (width)
      8:       taps = 16'h00e1;
      9:       taps = 16'h0110;
      10:      taps = 16'h0240;
      11:      taps = 16'h0500;
      12:      taps = 16'h0e08;
      13:      taps = 16'h1c80;
      14:      taps = 16'h3802;
      15:      taps = 16'h6000;
      default: taps = 16'hd008;
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/hpdcache_lfsr.sv
// Galois LFSR, resets to all-ones and advances one step only when shift_i is high.
module hpdcache_lfsr
  import hpdcache_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             shift_i,
  output logic [WIDTH-1:0] value_o
);

  localparam logic [15:0]      TAPS_FULL = hpdcache_lfsr_taps(WIDTH);
  localparam logic [WIDTH-1:0] TAPS      = TAPS_FULL[WIDTH-1:0];

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (shift_i) begin
      lfsr_d = {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= '1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/hpdcache_victim_rand.sv
// Pseudo-random victim way selection with a one-entry registered response.
// Optional HPDCACHE_VICTIM_INVALID_FIRST_EN prefers the lowest unlocked invalid way.
module hpdcache_victim_rand
  import hpdcache_pkg::*;
#(
  parameter int unsigned WAYS       = 4,
  parameter int unsigned LFSR_WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [WAYS-1:0] req_valid_ways_i,
  input  logic [WAYS-1:0] req_lock_ways_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic [WAYS-1:0] rsp_victim_o,
  output logic            rsp_none_o
);

  localparam int unsigned IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef logic [WAYS-1:0]  way_vec_t;
  typedef logic [IDX_W-1:0] way_idx_t;

  if (WAYS < 2 || WAYS > HPDCACHE_MAX_WAYS) begin : gen_bad_ways
    $fatal(1, "hpdcache_victim_rand: WAYS must be in 2..32");
  end
  if (LFSR_WIDTH < 8 || LFSR_WIDTH > 16) begin : gen_bad_lfsr
    $fatal(1, "hpdcache_victim_rand: LFSR_WIDTH must be in 8..16");
  end

  // Handshake: a request is taken when req_valid_i && req_ready_o; the
  // response is consumed when rsp_valid_o && rsp_ready_i and is held otherwise.
  logic req_accept;
  assign req_ready_o = !rsp_valid_o || rsp_ready_i;
  assign req_accept  = req_valid_i && req_ready_o;

  logic [LFSR_WIDTH-1:0] lfsr_value;

  hpdcache_lfsr #(
    .WIDTH (LFSR_WIDTH)
  ) i_lfsr (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .shift_i (req_accept),
    .value_o (lfsr_value)
  );

  logic [LFSR_WIDTH-1:0] start_full;
  way_idx_t              start_idx;
  assign start_full = lfsr_value % LFSR_WIDTH'(WAYS);
  assign start_idx  = way_idx_t'(start_full);

  way_vec_t rand_victim;
  logic     rand_found;

  // Upward search from the random start, wrapping at WAYS-1.
  always_comb begin
    int unsigned pos;
    way_idx_t    idx;
    rand_victim = '0;
    rand_found  = 1'b0;
    pos         = 0;
    idx         = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      pos = int'(start_idx) + i;
      if (pos >= WAYS) pos = pos - WAYS;
      idx = way_idx_t'(pos);
      if (!rand_found && !req_lock_ways_i[idx]) begin
        rand_victim[idx] = 1'b1;
        rand_found       = 1'b1;
      end
    end
  end

  way_vec_t sel_victim;
  logic     sel_none;
  assign sel_none = &req_lock_ways_i;

`ifdef HPDCACHE_VICTIM_INVALID_FIRST_EN
  way_vec_t inv_cand;
  way_vec_t inv_victim;
  assign inv_cand   = ~req_valid_ways_i & ~req_lock_ways_i;
  assign inv_victim = inv_cand & (~inv_cand + way_vec_t'(1));
  assign sel_victim = (|inv_cand) ? inv_victim : rand_victim;
`else
  logic unused_valid_ways;
  assign unused_valid_ways = ^req_valid_ways_i;
  assign sel_victim        = rand_victim;
`endif

  logic     rsp_valid_q;
  way_vec_t rsp_victim_q;
  logic     rsp_none_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q  <= 1'b0;
      rsp_victim_q <= '0;
      rsp_none_q   <= 1'b0;
    end else if (req_accept) begin
      rsp_valid_q  <= 1'b1;
      rsp_victim_q <= sel_victim;
      rsp_none_q   <= sel_none;
    end else if (rsp_ready_i) begin
      rsp_valid_q  <= 1'b0;
    end
  end

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_victim_o = rsp_victim_q;
  assign rsp_none_o   = rsp_none_q;

endmodule

// File: tb/tb_hpdcache_victim_rand.sv
// Directed bench for hpdcache_victim_rand (WAYS=4, LFSR_WIDTH=8, LFSR FF -> 9E -> 4F -> C6).
module tb_hpdcache_victim_rand;

  localparam int unsigned WAYS = 4;

  logic            clk;
  logic            rst_ni;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [WAYS-1:0] req_valid_ways_i;
  logic [WAYS-1:0] req_lock_ways_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [WAYS-1:0] rsp_victim_o;
  logic            rsp_none_o;

  int checks = 0;
  int errors = 0;

  hpdcache_victim_rand #(
    .WAYS       (WAYS),
    .LFSR_WIDTH (8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_valid_ways_i (req_valid_ways_i),
    .req_lock_ways_i  (req_lock_ways_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_victim_o     (rsp_victim_o),
    .rsp_none_o       (rsp_none_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_ni           = 1'b0;
    req_valid_i      = 1'b0;
    req_valid_ways_i = 4'b1111;
    req_lock_ways_i  = 4'b0000;
    rsp_ready_i      = 1'b1;
    step();
    step();
    rst_ni = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    req_valid_ways_i = 4'b1111;
    req_lock_ways_i = 4'b0000;
    rsp_ready_i = 1'b1;
    step();
    checks++;
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    checks++;
    if (rsp_victim_o !== 4'b0000) begin errors++; $display("FAIL reset_victim: got %b want 0000", rsp_victim_o); end
    checks++;
    if (rsp_none_o !== 1'b0) begin errors++; $display("FAIL reset_none: got %b want 0", rsp_none_o); end
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
  endtask

  // Back-to-back requests walk the LFSR: starts 3, 2, 3, 2.
  task automatic test_random_search();
    logic [WAYS-1:0] exp_v [4];
    exp_v[0] = 4'b1000; exp_v[1] = 4'b0100; exp_v[2] = 4'b1000; exp_v[3] = 4'b0100;
    apply_reset();
    req_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_victim_o !== exp_v[i] || rsp_none_o !== 1'b0) begin
        errors++;
        $display("FAIL random_search[%0d]: got valid=%b victim=%b none=%b want valid=1 victim=%b none=0",
                 i, rsp_valid_o, rsp_victim_o, rsp_none_o, exp_v[i]);
      end
    end
    req_valid_i = 1'b0;
    step();
    checks++;
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL random_drain: got valid=%b want 0", rsp_valid_o); end
  endtask

  task automatic test_lock_wrap();
    apply_reset();
    req_lock_ways_i = 4'b1000;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_victim_o !== 4'b0001 || rsp_none_o !== 1'b0) begin
      errors++; $display("FAIL lock_wrap: got victim=%b none=%b want 0001/0", rsp_victim_o, rsp_none_o);
    end
    // start 2 with ways 2,3 locked wraps to way 0
    req_lock_ways_i = 4'b1100;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_victim_o !== 4'b0001) begin errors++; $display("FAIL lock_wrap2: got victim=%b want 0001", rsp_victim_o); end
    req_lock_ways_i = 4'b0000;
    step();
  endtask

  task automatic test_all_locked();
    apply_reset();
    req_lock_ways_i = 4'b1111;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_victim_o !== 4'b0000 || rsp_none_o !== 1'b1) begin
      errors++;
      $display("FAIL all_locked: got valid=%b victim=%b none=%b want 1/0000/1", rsp_valid_o, rsp_victim_o, rsp_none_o);
    end
    // LFSR still shifted on this accept, so next start is 2
    req_lock_ways_i = 4'b0000;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_victim_o !== 4'b0100 || rsp_none_o !== 1'b0) begin
      errors++; $display("FAIL after_all_locked: got victim=%b none=%b want 0100/0", rsp_victim_o, rsp_none_o);
    end
    step();
  endtask

  task automatic test_invalid_first();
    logic [WAYS-1:0] exp_v;
`ifdef HPDCACHE_VICTIM_INVALID_FIRST_EN
    exp_v = 4'b0100;
`else
    exp_v = 4'b1000;
`endif
    apply_reset();
    req_valid_ways_i = 4'b1011;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    req_valid_ways_i = 4'b1111;
    checks++;
    if (rsp_victim_o !== exp_v) begin errors++; $display("FAIL invalid_first: got victim=%b want %b", rsp_victim_o, exp_v); end
    // LFSR shifted regardless of the selection path
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_victim_o !== 4'b0100) begin errors++; $display("FAIL invalid_first_next: got victim=%b want 0100", rsp_victim_o); end
    step();
  endtask

  task automatic test_stall();
    apply_reset();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    step();
    req_lock_ways_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_victim_o !== 4'b1000 || rsp_none_o !== 1'b0 || req_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b victim=%b none=%b ready=%b want 1/1000/0/0",
                 i, rsp_valid_o, rsp_victim_o, rsp_none_o, req_ready_o);
      end
      step();
    end
    req_lock_ways_i = 4'b0000;
    rsp_ready_i = 1'b1;
    #1;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", req_ready_o); end
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_victim_o !== 4'b0100) begin
      errors++; $display("FAIL stall_next: got valid=%b victim=%b want 1/0100", rsp_valid_o, rsp_victim_o);
    end
    step();
    checks++;
    if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_drain: got valid=%b want 0", rsp_valid_o); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if (rsp_valid_o !== 1'b0 || rsp_victim_o !== 4'b0000) begin
      errors++; $display("FAIL reset_mid_drop: got valid=%b victim=%b want 0/0000", rsp_valid_o, rsp_victim_o);
    end
    step();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b1 || rsp_victim_o !== 4'b1000) begin
      errors++; $display("FAIL reset_mid_first: got valid=%b victim=%b want 1/1000", rsp_valid_o, rsp_victim_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_random_search();
    test_lock_wrap();
    test_all_locked();
    test_invalid_first();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
